// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits LSB first,
// optional parity bit, stop bit. Every output is taken straight from a flip-flop.
module serial_frame_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             txd,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic HAS_PAR = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div, div_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic               par_bit, par_n;
    logic               bit_end;
    logic               txd_n, ready_n, busy_n, done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            txd        <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            div        <= div_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            par_bit    <= par_n;
            txd        <= txd_n;
            tx_ready   <= ready_n;
            busy       <= busy_n;
            frame_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par_bit;
        done_n  = 1'b0;
        bit_end = (div == DIV_LAST);

        if (state == IDLE) begin
            div_n = '0;
            // tx_ready is the registered image of state==IDLE
            if (tx_valid && tx_ready) begin
                shreg_n = tx_data;
                par_n   = (^tx_data) ^ PAR_ODD;
                state_n = START;
            end
        end else begin
            div_n = bit_end ? '0 : div + DIV_W'(1);
            case (state)
                START: begin
                    if (bit_end) begin
                        idx_n   = '0;
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg_n = shreg >> 1;
                        idx_n   = idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
                            state_n = HAS_PAR ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_n = STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Line level is decoded from the next state so txd stays a pure register output
    always_comb begin
        txd_n = 1'b1;
        case (state_n)
            IDLE:    txd_n = 1'b1;
            START:   txd_n = 1'b0;
            DATA:    txd_n = shreg_n[0];
            PARITY:  txd_n = par_n;
            STOP:    txd_n = 1'b1;
            default: txd_n = 1'b1;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances (even parity, odd parity, no parity)
// with a line monitor that pops expected frames from a scoreboard queue.
module tb_serial_frame_tx;

    localparam int CPB = 4;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       par;
    } vec_t;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       par;
        int         edge_cyc;
        bit         b2b;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data_v  [3];
    logic       tx_valid_v [3];
    logic       tx_ready_v [3];
    logic       txd_v      [3];
    logic       busy_v     [3];
    logic       done_v     [3];

    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t sb [$];
    bit   active    [3];
    int   pos       [3];
    exp_t cur       [3];
    int   last_done [3];
    vec_t vecs      [10];

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]),
        .tx_ready(tx_ready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]),
        .tx_ready(tx_ready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut_nopar (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_v[2]), .tx_valid(tx_valid_v[2]),
        .tx_ready(tx_ready_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst=%0d t=%0t: got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    function automatic int frame_bits(input int g);
        return (g == 2) ? 10 : 11;
    endfunction

    function automatic logic exp_bit(input exp_t e, input int g, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return e.data[k-1];
        if (k == frame_bits(g) - 1) return 1'b1;
        return e.par;
    endfunction

    // obs packs {txd, busy, tx_ready, frame_done}
    task automatic monitor_step();
        logic [3:0] obs;
        for (int g = 0; g < 3; g++) begin
            obs = {txd_v[g], busy_v[g], tx_ready_v[g], done_v[g]};
            if (!rst_n) begin
                active[g] = 1'b0;
                continue;
            end
            if (!active[g]) begin
                if (txd_v[g] == 1'b0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_start", g, 32'd1, 32'd0);
                    end else begin
                        cur[g] = sb.pop_front();
                        check("sb_inst", g, cur[g].inst, g);
                        check("start_latency", g, cyc, cur[g].edge_cyc);
                        if (cur[g].b2b) check("b2b_gap", g, cyc, last_done[g] + 1);
                        check("start_bit", g, {28'd0, obs}, 32'h4);
                        active[g] = 1'b1;
                        pos[g]    = 0;
                    end
                end else begin
                    check("idle", g, {28'd0, obs}, 32'hA);
                end
            end else begin
                pos[g]++;
                if (pos[g] < frame_bits(g) * CPB) begin
                    check("frame_bit", g, {28'd0, obs},
                          {28'd0, exp_bit(cur[g], g, pos[g] / CPB), 3'b100});
                end else begin
                    check("frame_end", g, {28'd0, obs}, 32'hB);
                    active[g]    = 1'b0;
                    last_done[g] = cyc;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge with tx_valid still high.
    task automatic send(input int g, input logic [7:0] d, input logic par, input bit b2b);
        int   n;
        exp_t e;
        n = 0;
        tx_data_v[g]  = d;
        tx_valid_v[g] = 1'b1;
        while (!tx_ready_v[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("ready_timeout", g, 32'd0, 32'd1);
        end else begin
            e = '{inst: g, data: d, par: par, edge_cyc: cyc + 1, b2b: b2b};
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tx_data_v[g]  = '0;
            tx_valid_v[g] = 1'b0;
            active[g]     = 1'b0;
            pos[g]        = 0;
            last_done[g]  = 0;
        end
        vecs[0] = '{inst: 0, data: 8'hA5, par: 1'b0};
        vecs[1] = '{inst: 0, data: 8'h3C, par: 1'b0};
        vecs[2] = '{inst: 0, data: 8'h01, par: 1'b1};
        vecs[3] = '{inst: 0, data: 8'h80, par: 1'b1};
        vecs[4] = '{inst: 0, data: 8'h00, par: 1'b0};
        vecs[5] = '{inst: 0, data: 8'hFE, par: 1'b1};
        vecs[6] = '{inst: 1, data: 8'h07, par: 1'b0};
        vecs[7] = '{inst: 1, data: 8'hA5, par: 1'b1};
        vecs[8] = '{inst: 2, data: 8'h07, par: 1'b0};
        vecs[9] = '{inst: 2, data: 8'h80, par: 1'b0};

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset held for 3 cycles, then 20 idle cycles
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++)
            check("reset_state", g, {28'd0, txd_v[g], busy_v[g], tx_ready_v[g], done_v[g]}, 32'hA);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].inst, vecs[i].data, vecs[i].par, 1'b0);
            tx_valid_v[vecs[i].inst] = 1'b0;
            repeat (50) @(negedge clk);
        end

        // Input changes after the transfer must not reach the line
        send(0, 8'h3C, 1'b0, 1'b0);
        tx_valid_v[0] = 1'b0;
        tx_data_v[0]  = 8'hFF;
        repeat (50) @(negedge clk);

        // Back-to-back with tx_valid held high
        send(0, 8'h01, 1'b1, 1'b0);
        send(0, 8'h80, 1'b1, 1'b1);
        tx_valid_v[0] = 1'b0;
        repeat (50) @(negedge clk);

        // Asynchronous reset during data bit 3, with tx_valid asserted during reset
        send(0, 8'hFF, 1'b0, 1'b0);
        tx_valid_v[0] = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_reset_busy", 0, {31'd0, busy_v[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 0, {28'd0, txd_v[0], busy_v[0], tx_ready_v[0], done_v[0]}, 32'hA);
        tx_data_v[0]  = 8'hC3;
        tx_valid_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        tx_valid_v[0] = 1'b0;
        rst_n         = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        send(0, 8'h55, 1'b0, 1'b0);
        tx_valid_v[0] = 1'b0;
        repeat (50) @(negedge clk);

        check("sb_drained", 0, sb.size(), 0);
        for (int g = 0; g < 3; g++)
            check("monitor_idle", g, {31'd0, active[g]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
